// File: rtl/fwft_frame_packer_if.sv
// Read side of an FWFT FIFO plus the framed valid/ready output stream of the packer.
// The packer connects through "master"; the FIFO/sink environment connects through "slave".
interface fwft_frame_packer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_vld;
    logic                  in_rden;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        input  in_data, in_vld, out_ready,
        output in_rden, out_data, out_valid, out_sof, out_eof
    );

    modport slave (
        output in_data, in_vld, out_ready,
        input  in_rden, out_data, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/fwft_frame_packer.sv
// Groups FWFT FIFO words into frames, each closed by count limit, idle timeout or flush
// and terminated by a trailer word {TAG, seq, length}.
module fwft_frame_packer #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         MAX_PAYLOAD    = 256,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] TRAILER_TAG    = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                flush,
    fwft_frame_packer_if.master bus,
    output logic                frame_open,
    output logic [7:0]          seq_num
);
    localparam int              TW            = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]   TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMEOUT_ONE   = TW'(1);
    localparam logic [15:0]     COUNT_LIMIT   = 16'(MAX_PAYLOAD);
    localparam bit              TIMEOUT_ON    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  sof_reg, sof_next;
    logic                  eof_reg, eof_next;
    logic [15:0]           count_reg, count_next;
    logic [TW-1:0]         timeout_reg, timeout_next;
    logic [7:0]            seq_reg, seq_next;

    logic                  free;
    logic                  rden;
    logic                  accept;
    logic [15:0]           count_inc;
    logic [TW-1:0]         timeout_inc;
    logic [DATA_WIDTH-1:0] trailer_word;

    // Output register can take a new word when empty or being drained this cycle.
    assign free        = !valid_reg || bus.out_ready;
    assign rden        = free && enable && !flush && (state_reg == IDLE || state_reg == PAYLOAD);
    assign accept      = rden && bus.in_vld;
    assign count_inc   = count_reg + 16'd1;
    assign timeout_inc = timeout_reg + TIMEOUT_ONE;

    always_comb begin
        trailer_word       = '0;
        trailer_word[31:0] = {TRAILER_TAG, seq_reg, count_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            sof_reg     <= 1'b0;
            eof_reg     <= 1'b0;
            count_reg   <= '0;
            timeout_reg <= '0;
            seq_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            sof_reg     <= sof_next;
            eof_reg     <= eof_next;
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
            seq_reg     <= seq_next;
        end
    end

    // Popping is blocked by flush, so the count limit and flush/timeout can never
    // both fire on the same edge: exactly one trailer per frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (COUNT_LIMIT == 16'd1) ? TRAILER : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (count_inc == COUNT_LIMIT) begin
                        state_next = TRAILER;
                    end
                end else if (flush || (TIMEOUT_ON && timeout_inc == TIMEOUT_LIMIT)) begin
                    state_next = TRAILER;
                end
            end
            TRAILER: begin
                if (free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        sof_next     = sof_reg;
        eof_next     = eof_reg;
        count_next   = count_reg;
        timeout_next = timeout_reg;
        seq_next     = seq_reg;
        if (free) begin
            valid_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next    = bus.in_data;
                    valid_next   = 1'b1;
                    sof_next     = 1'b1;
                    eof_next     = 1'b0;
                    count_next   = 16'd1;
                    timeout_next = '0;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    data_next    = bus.in_data;
                    valid_next   = 1'b1;
                    sof_next     = 1'b0;
                    eof_next     = 1'b0;
                    count_next   = count_inc;
                    timeout_next = '0;
                end else begin
                    // Stalls on out_ready or enable still count as idle time.
                    timeout_next = timeout_inc;
                end
            end
            TRAILER: begin
                if (free) begin
                    data_next    = trailer_word;
                    valid_next   = 1'b1;
                    sof_next     = 1'b0;
                    eof_next     = 1'b1;
                    seq_next     = seq_reg + 8'd1;
                    count_next   = '0;
                    timeout_next = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_rden   = rden;
    assign bus.out_data  = data_reg;
    assign bus.out_valid = valid_reg;
    assign bus.out_sof   = sof_reg;
    assign bus.out_eof   = eof_reg;
    assign frame_open    = (state_reg == PAYLOAD) || (state_reg == TRAILER);
    assign seq_num       = seq_reg;
endmodule

// File: tb/tb_fwft_frame_packer.sv
// Scoreboard bench for fwft_frame_packer: FIFO model feeds words, expected frames are queued
// at stimulus time and compared on every output handshake.
module tb_fwft_frame_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct {
        int          n;
        bit          do_flush;
        int          delay;
        logic [31:0] trailer;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_seq = 8'd0;
    int          ready_mode = 0;

    // Main instance: MAX_PAYLOAD=4, TIMEOUT_CYCLES=1024
    fwft_frame_packer_if #(.DATA_WIDTH(32)) bus_a ();
    logic       en_a = 1'b0;
    logic       flush_a = 1'b0;
    logic       frame_open_a;
    logic [7:0] seq_a;
    fwft_frame_packer #(.DATA_WIDTH(32), .MAX_PAYLOAD(4), .TIMEOUT_CYCLES(1024), .TRAILER_TAG(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .flush(flush_a), .bus(bus_a),
        .frame_open(frame_open_a), .seq_num(seq_a)
    );

    // Short-timeout and timeout-disabled instances
    fwft_frame_packer_if #(.DATA_WIDTH(32)) bus_b ();
    fwft_frame_packer_if #(.DATA_WIDTH(32)) bus_c ();
    logic       en_bc = 1'b1;
    logic       flush_bc = 1'b0;
    logic       frame_open_b, frame_open_c;
    logic [7:0] seq_b, seq_c;
    fwft_frame_packer #(.DATA_WIDTH(32), .MAX_PAYLOAD(4), .TIMEOUT_CYCLES(8), .TRAILER_TAG(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .enable(en_bc), .flush(flush_bc), .bus(bus_b),
        .frame_open(frame_open_b), .seq_num(seq_b)
    );
    fwft_frame_packer #(.DATA_WIDTH(32), .MAX_PAYLOAD(4), .TIMEOUT_CYCLES(0), .TRAILER_TAG(8'hA5)) dut_c (
        .clk(clk), .rst(rst), .enable(en_bc), .flush(flush_bc), .bus(bus_c),
        .frame_open(frame_open_c), .seq_num(seq_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] d, input bit sof);
        exp_t e;
        e.data = d;
        e.sof  = sof;
        e.eof  = 1'b0;
        fifo_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic push_trailer(input logic [31:0] t);
        exp_t e;
        e.data = t;
        e.sof  = 1'b0;
        e.eof  = 1'b1;
        exp_q.push_back(e);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic push_frame(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) push_word(first + 32'(i), i == 0);
        push_trailer({8'hA5, exp_seq, 16'(n)});
    endtask

    task automatic wait_fifo_empty(input int budget);
        int k = 0;
        while (fifo_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("fifo_drained", 64'(fifo_q.size()), 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("output_drained", 64'(exp_q.size()), 64'd0);
        repeat (4) tick();
    endtask

    task automatic pulse_flush();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
    endtask

    // FIFO model: a word leaves on any edge where in_vld && in_rden.
    always @(posedge clk) begin
        if (!rst && bus_a.in_vld && bus_a.in_rden && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
    end

    // Monitor and input driver for instance A, working between edges.
    logic        hold_pending = 1'b0;
    logic [31:0] held_data;
    logic        held_sof, held_eof;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending    = 1'b0;
            bus_a.out_ready = 1'b1;
            bus_a.in_vld    = 1'b0;
            bus_a.in_data   = '0;
        end else begin
            if (hold_pending) begin
                chk("stall_valid", 64'(bus_a.out_valid), 64'd1);
                chk("stall_word", {30'd0, bus_a.out_sof, bus_a.out_eof, bus_a.out_data},
                    {30'd0, held_sof, held_eof, held_data});
            end
            case (ready_mode)
                0:       bus_a.out_ready = 1'b1;
                1:       bus_a.out_ready = 1'($urandom_range(0, 1));
                default: bus_a.out_ready = 1'b0;
            endcase
            if (bus_a.out_valid && bus_a.out_ready) begin
                $display("[TB] out data=0x%08h sof=%0b eof=%0b", bus_a.out_data, bus_a.out_sof, bus_a.out_eof);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", bus_a.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_word", {30'd0, bus_a.out_sof, bus_a.out_eof, bus_a.out_data},
                        {30'd0, e.sof, e.eof, e.data});
                end
            end
            hold_pending = bus_a.out_valid && !bus_a.out_ready;
            held_data    = bus_a.out_data;
            held_sof     = bus_a.out_sof;
            held_eof     = bus_a.out_eof;
            bus_a.in_vld  = (fifo_q.size() > 0);
            bus_a.in_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
        end
    end

    initial begin
        vec_t vecs[4];
        int   k;
        int   b_sof_idx, b_eof_idx, c_eof, c_words;
        logic [31:0] b_trl;

        vecs[0] = '{n: 4, do_flush: 1'b0, delay: 0, trailer: 32'hA503_0004};
        vecs[1] = '{n: 1, do_flush: 1'b1, delay: 3, trailer: 32'hA504_0001};
        vecs[2] = '{n: 3, do_flush: 1'b1, delay: 1, trailer: 32'hA505_0003};
        vecs[3] = '{n: 2, do_flush: 1'b1, delay: 0, trailer: 32'hA506_0002};

        bus_b.in_vld = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
        bus_c.in_vld = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b1;

        repeat (3) tick();
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
        chk("rst_sof_eof", {62'd0, bus_a.out_sof, bus_a.out_eof}, 64'd0);
        chk("rst_seq", 64'(seq_a), 64'd0);
        chk("rst_frame_open", 64'(frame_open_a), 64'd0);
        chk("rst_in_rden", 64'(bus_a.in_rden), 64'd0);
        rst  = 1'b0;
        en_a = 1'b1;
        tick();

        // Ten words, count-limited frames, last frame closed by the 1024-cycle timeout
        push_frame(32'd1, 4);
        push_frame(32'd5, 4);
        push_frame(32'd9, 2);
        wait_fifo_empty(100);
        repeat (500) tick();
        chk("open_before_timeout", 64'(frame_open_a), 64'd1);
        chk("trailer_pending", 64'(exp_q.size()), 64'd1);
        wait_drain(1000);

        // Table of count- and flush-closed frames
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < vecs[i].n; j++) push_word(32'h1000 * (i + 1) + 32'(j), j == 0);
            push_trailer(vecs[i].trailer);
            wait_fifo_empty(50);
            repeat (vecs[i].delay) tick();
            if (vecs[i].do_flush) pulse_flush();
            wait_drain(50);
        end
        chk("seq_after_table", 64'(seq_a), 64'd7);

        // Flush while a word is waiting: that word must stay in the FIFO
        en_a = 1'b0;
        push_word(32'h100, 1'b1);
        push_trailer({8'hA5, exp_seq, 16'd1});
        push_word(32'h101, 1'b1);
        push_trailer({8'hA5, exp_seq, 16'd1});
        tick();
        en_a = 1'b1;
        k = 0;
        while (fifo_q.size() != 1 && k < 20) begin
            tick();
            k++;
        end
        pulse_flush();
        chk("flush_no_pop", 64'(fifo_q.size()), 64'd1);
        wait_fifo_empty(20);
        pulse_flush();
        wait_drain(50);

        // Flush in IDLE produces nothing
        pulse_flush();
        repeat (5) tick();
        chk("idle_flush_valid", 64'(bus_a.out_valid), 64'd0);
        chk("idle_flush_open", 64'(frame_open_a), 64'd0);
        chk("idle_flush_seq", 64'(seq_a), 64'(exp_seq));

        // 1000 random words with random out_ready; sequence wraps past 255
        ready_mode = 1;
        for (int f = 0; f < 250; f++) begin
            for (int j = 0; j < 4; j++) push_word($urandom, j == 0);
            push_trailer({8'hA5, exp_seq, 16'd4});
        end
        wait_drain(20000);
        ready_mode = 0;
        tick();
        chk("seq_after_random", 64'(seq_a), 64'(exp_seq));

        // Reset mid-frame with a stalled word on the output
        ready_mode = 2;
        fifo_q.push_back(32'hDEAD_BEEF);
        k = 0;
        while (!bus_a.out_valid && k < 20) begin
            tick();
            k++;
        end
        chk("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("mid_rst_data", 64'(bus_a.out_data), 64'd0);
        chk("mid_rst_seq", 64'(seq_a), 64'd0);
        chk("mid_rst_open", 64'(frame_open_a), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        exp_seq = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        ready_mode = 0;
        push_word(32'h55, 1'b1);
        push_trailer(32'hA500_0001);
        wait_fifo_empty(20);
        repeat (2) tick();
        pulse_flush();
        wait_drain(50);
        chk("seq_after_rst_frame", 64'(seq_a), 64'd1);

        // Exact 8-cycle timeout on B, no timeout at all on C
        b_sof_idx = -1; b_eof_idx = -1; c_eof = 0; c_words = 0; b_trl = '0;
        bus_b.in_vld = 1'b1; bus_b.in_data = 32'h77;
        bus_c.in_vld = 1'b1; bus_c.in_data = 32'h88;
        @(negedge clk);
        chk("b_rden", 64'(bus_b.in_rden), 64'd1);
        chk("c_rden", 64'(bus_c.in_rden), 64'd1);
        @(posedge clk);
        #2;
        bus_b.in_vld = 1'b0;
        bus_c.in_vld = 1'b0;
        for (int idx = 0; idx < 2000; idx++) begin
            @(negedge clk);
            if (bus_b.out_valid) begin
                if (bus_b.out_sof) b_sof_idx = idx;
                if (bus_b.out_eof) begin
                    b_eof_idx = idx;
                    b_trl = bus_b.out_data;
                end
            end
            if (bus_c.out_valid) begin
                if (bus_c.out_eof) c_eof++;
                else c_words++;
            end
        end
        $display("[TB] timeout instance: sof at %0d, trailer at %0d", b_sof_idx, b_eof_idx);
        chk("b_sof_idx", 64'(b_sof_idx), 64'd0);
        chk("b_timeout_gap", 64'(b_eof_idx - b_sof_idx), 64'd9);
        chk("b_trailer", 64'(b_trl), 64'hA500_0001);
        chk("c_no_trailer", 64'(c_eof), 64'd0);
        chk("c_one_word", 64'(c_words), 64'd1);
        chk("c_still_open", 64'(frame_open_c), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fwft_frame_packer.md
Name: fwft_frame_packer

Overview:
- Sits directly downstream of the dual-clock FWFT FIFO, in its read-clock domain.
- Pops words from the FIFO's first-word-fall-through read port and groups them into frames on a valid/ready output stream.
- Closes a frame on a word-count limit, an idle timeout, or an explicit flush.
- Each frame ends with a trailer word carrying a tag, sequence number and payload length, so downstream logic can delimit and check frames.

Parameters:
- DATA_WIDTH, 32, word width; must be >= 32.
- MAX_PAYLOAD, 256, payload words per frame before forced close; range 1..65535.
- TIMEOUT_CYCLES, 1024, consecutive idle cycles in an open frame before close; 0 disables the timeout.
- TRAILER_TAG, 8'hA5, tag placed in trailer bits [31:24].

Ports:
- clk, in, 1, single clock (FIFO rdclk).
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, when low no new words are popped.
- flush, in, 1, single-cycle request to close the open frame.
- in_data, in, DATA_WIDTH, FIFO rdata.
- in_vld, in, 1, FIFO rdata_vld.
- in_rden, out, 1, FIFO rden; a word is consumed on any edge where in_vld && in_rden.
- out_data, out, DATA_WIDTH, stream data.
- out_valid, out, 1, stream valid.
- out_ready, in, 1, stream ready.
- out_sof, out, 1, first payload word of a frame.
- out_eof, out, 1, trailer word (last of frame).
- frame_open, out, 1, high while in the PAYLOAD or TRAILER state.
- seq_num, out, 8, sequence number of the next trailer.

Behaviour:
- Reset (async assert, sync deassert release): state IDLE; out_data=0; out_valid=0; out_sof=0; out_eof=0; in_rden=0; seq_num=0; payload count=0; timeout count=0. A reset mid-frame discards the frame silently; no trailer is emitted.
- Output register: single stage.
  - out_data, out_sof and out_eof are held stable while out_valid && !out_ready.
  - The register is free when !out_valid || out_ready.
- FSM states: IDLE, PAYLOAD, TRAILER.
- in_rden = free && enable && !flush && state in {IDLE, PAYLOAD}. It is combinational from out_ready, with no extra latency.
- Word acceptance: a word accepted at edge N is on out_data with out_valid=1 after edge N. Throughput is 1 word/cycle with out_ready held high.
- IDLE:
  - Accepted word → load it with out_sof=1, count=1, timeout=0, go to PAYLOAD.
  - flush is ignored.
  - Empty frames are never produced.
- PAYLOAD:
  - Accepted word → load it with out_sof=0, count+1, timeout cleared.
  - If the new count == MAX_PAYLOAD → go to TRAILER. With MAX_PAYLOAD=1 this goes straight from IDLE to TRAILER.
  - No word accepted → timeout increments. It also increments while stalled by out_ready or enable.
  - Timeout reaches TIMEOUT_CYCLES (nonzero) → go to TRAILER.
  - flush high → go to TRAILER; the word present that cycle is not popped.
  - If count limit and flush/timeout coincide: one trailer only.
- TRAILER:
  - When the register is free, load {zeros, TRAILER_TAG, seq_num, count[15:0]} with out_eof=1 and out_sof=0.
  - Then increment seq_num (wraps 255→0), clear count, go to IDLE.
  - No words are popped in this state.
- After a trailer is loaded, the next frame's first word may be accepted on the following cycle.
- Width rules:
  - count is 16 bits.
  - The timeout counter is wide enough for TIMEOUT_CYCLES.
  - Trailer bits above 31 are zero.

Test Plan:
- MAX_PAYLOAD=4; FIFO holds 10 words 1..10; out_ready=1 → frames [1,2,3,4,T(A5,00,0004)], [5..8,T(A5,01,0004)], [9,10]. The last frame then closes after 1024 idle cycles with T(A5,02,0002).
- Random out_ready (50%) over 1000 words → output payload sequence matches input exactly; no duplicates or drops; data stable during stalls.
- Single word then flush 3 cycles later → out: word(sof=1), T(A5,00,0001,eof=1). flush while IDLE → no output.
- TIMEOUT_CYCLES=8, one word then FIFO empty → trailer appears after exactly 8 idle cycles. TIMEOUT_CYCLES=0 → no trailer ever appears.
- 256 frames → seq_num wraps 255→0; trailer seq field increments monotonically modulo 256.
- rst asserted mid-frame with out_valid=1 → outputs 0 immediately. The next frame starts with sof and seq=0.
